normalize_round_fp: RTL and testbench

//  Parametrised normalise-and-round back end for the FP adder/MAC datapath; successor to the fixed FP32 normaliser.

---
 rtl/normalize_round_fp.sv | 143 ++++++++++++++
 tb/tb_normalize_round_fp.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/normalize_round_fp.sv
// Normalise-and-round back end for the FP adder/MAC datapath: leading-zero count,
// normalising shift, four rounding modes and special-case packing over 3 pipelined stages.
module normalize_round_fp #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int IN_W  = 49
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_sign,
   input  logic [EXP_W-1:0]     in_exp,
   input  logic [IN_W-1:0]      in_mant,
   input  logic [1:0]           in_rmode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] out_data,
   output logic [3:0]           out_flags
);
   localparam int LZ_W  = $clog2(IN_W + 1);
   localparam int E_W   = EXP_W + 2;
   localparam int STK_W = IN_W - MAN_W - 2;
   localparam logic signed [E_W-1:0] E_MAX  = E_W'((1 << EXP_W) - 1);
   localparam logic signed [E_W-1:0] E_ZERO = '0;

   logic stall;
   logic v1, v2, v3;

   assign stall     = v3 & ~out_ready;
   assign in_ready  = ~stall;
   assign out_valid = v3;

   logic [LZ_W-1:0] lz_c;

   always_comb begin
      lz_c = LZ_W'(IN_W);
      for (int i = 0; i < IN_W; i++)
         if (in_mant[i]) lz_c = LZ_W'(IN_W - 1 - i);
   end

   logic             s1_sign;
   logic [EXP_W-1:0] s1_exp;
   logic [IN_W-1:0]  s1_mant;
   logic [1:0]       s1_rmode;
   logic [LZ_W-1:0]  s1_lz;

   logic signed [E_W-1:0] e_c;
   logic [IN_W-1:0]       shifted_c;

   always_comb begin
      e_c       = E_W'(s1_exp) + E_W'(1) - E_W'(s1_lz);
      shifted_c = s1_mant << s1_lz;
   end

   logic                  s2_sign;
   logic [1:0]            s2_rmode;
   logic signed [E_W-1:0] s2_e;
   logic [MAN_W-1:0]      s2_frac;
   logic                  s2_g;
   logic                  s2_s;
   logic                  s2_inf_nan;
   logic                  s2_zero;

   logic                  inc_c;
   logic                  carry_c;
   logic                  inexact_c;
   logic                  to_inf_c;
   logic [MAN_W-1:0]      frac_r_c;
   logic signed [E_W-1:0] e_r_c;
   logic [EXP_W+MAN_W:0]  data_c;
   logic [3:0]            flags_c;

   always_comb begin
      inexact_c = s2_g | s2_s;
      case (s2_rmode)
         2'd0:    inc_c = s2_g & (s2_s | s2_frac[0]);
         2'd1:    inc_c = 1'b0;
         2'd2:    inc_c = ~s2_sign & inexact_c;
         default: inc_c = s2_sign & inexact_c;
      endcase
      {carry_c, frac_r_c} = {1'b0, s2_frac} + (MAN_W+1)'(inc_c);
      e_r_c    = s2_e + E_W'(carry_c);
      to_inf_c = (s2_rmode == 2'd0) | ((s2_rmode == 2'd2) & ~s2_sign)
               | ((s2_rmode == 2'd3) & s2_sign);
      data_c   = {s2_sign, e_r_c[EXP_W-1:0], frac_r_c};
      flags_c  = {2'b00, inexact_c, 1'b0};
      // Priority: inf/NaN input, exact zero, flush-to-zero, overflow, normal
      if (s2_inf_nan) begin
         data_c  = {s2_sign, {EXP_W{1'b1}},
                    s2_zero ? {MAN_W{1'b0}} : {1'b1, {(MAN_W-1){1'b0}}}};
         flags_c = 4'b0000;
      end else if (s2_zero) begin
         data_c  = {s2_sign, {(EXP_W+MAN_W){1'b0}}};
         flags_c = 4'b0001;
      end else if (s2_e <= E_ZERO) begin
         data_c  = {s2_sign, {(EXP_W+MAN_W){1'b0}}};
         flags_c = 4'b0111;
      end else if (e_r_c >= E_MAX) begin
         data_c  = to_inf_c ? {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                            : {s2_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
         flags_c = 4'b1010;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         v3        <= 1'b0;
         out_data  <= '0;
         out_flags <= '0;
      end else if (!stall) begin
         v1 <= in_valid;
         v2 <= v1;
         v3 <= v2;
         if (v2) begin
            out_data  <= data_c;
            out_flags <= flags_c;
         end
      end
   end

   // Datapath registers carry no reset; the valid bits qualify them.
   always_ff @(posedge clk) begin
      if (!stall) begin
         s1_sign    <= in_sign;
         s1_exp     <= in_exp;
         s1_mant    <= in_mant;
         s1_rmode   <= in_rmode;
         s1_lz      <= lz_c;
         s2_sign    <= s1_sign;
         s2_rmode   <= s1_rmode;
         s2_e       <= e_c;
         s2_frac    <= shifted_c[IN_W-2 -: MAN_W];
         s2_g       <= shifted_c[STK_W];
         s2_s       <= |shifted_c[STK_W-1:0];
         s2_inf_nan <= &s1_exp;
         s2_zero    <= ~shifted_c[IN_W-1];
      end
   end

endmodule

// File: tb/tb_normalize_round_fp.sv
// Scoreboard bench for normalize_round_fp: directed spec vectors plus random beats
// checked against a value-level rounding model, with backpressure and reset flush.
module tb_normalize_round_fp;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [7:0]  in_exp;
   logic [48:0] in_mant;
   logic [1:0]  in_rmode;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [3:0]  out_flags;

   always #5 clk = ~clk;

   normalize_round_fp dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sign   (in_sign),
      .in_exp    (in_exp),
      .in_mant   (in_mant),
      .in_rmode  (in_rmode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_flags (out_flags)
   );

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  f;
   } res_t;

   res_t        q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          rdy_mode = 0;
   logic        dir_en = 1'b0;
   res_t        dir_res;
   logic        stall_prev = 1'b0;
   logic [31:0] prev_d;
   logic [3:0]  prev_f;

   task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual %h required %h", nm, act, req);
      end
   endtask

   // Value-level model: find the leading one, keep 24 significant bits, and
   // round the discarded remainder by comparing it against half an ulp.
   function automatic res_t model(input logic sg, input logic [7:0] ex,
                                  input logic [48:0] mt, input logic [1:0] rm);
      res_t r;
      longint unsigned m, keep, rem, half;
      int p, e, sh;
      logic up, to_inf;
      m = 64'(mt);
      if (ex == 8'hFF) begin
         r.d = {sg, 8'hFF, (mt == 0) ? 23'h0 : 23'h400000};
         r.f = 4'b0000;
         return r;
      end
      if (mt == 0) begin
         r.d = {sg, 31'h0};
         r.f = 4'b0001;
         return r;
      end
      p = 0;
      for (int i = 0; i < 49; i++) if (m[i]) p = i;
      e = int'(ex) + p - 47;
      if (e <= 0) begin
         r.d = {sg, 31'h0};
         r.f = 4'b0111;
         return r;
      end
      if (p > 23) begin
         sh   = p - 23;
         keep = m >> sh;
         rem  = m & ((64'd1 << sh) - 1);
         half = 64'd1 << (sh - 1);
      end else begin
         keep = m << (23 - p);
         rem  = 0;
         half = 1;
      end
      case (rm)
         2'd0:    up = (rem > half) || (rem == half && keep[0]);
         2'd1:    up = 1'b0;
         2'd2:    up = !sg && rem != 0;
         default: up = sg && rem != 0;
      endcase
      keep = keep + 64'(up);
      if (keep == (64'd1 << 24)) begin
         keep = 64'd1 << 23;
         e++;
      end
      if (e >= 255) begin
         to_inf = (rm == 2'd0) || (rm == 2'd2 && !sg) || (rm == 2'd3 && sg);
         r.d = to_inf ? {sg, 8'hFF, 23'h0} : {sg, 8'hFE, 23'h7FFFFF};
         r.f = 4'b1010;
         return r;
      end
      r.d = {sg, e[7:0], keep[22:0]};
      r.f = {2'b00, rem != 0, 1'b0};
      return r;
   endfunction

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         1:       out_ready = 1'b0;
         2:       out_ready = ($urandom_range(0, 3) != 0);
         default: out_ready = 1'b1;
      endcase
   end

   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         stall_prev = 1'b0;
      end else begin
         if (in_valid && in_ready)
            q.push_back(dir_en ? dir_res : model(in_sign, in_exp, in_mant, in_rmode));
         if (stall_prev)
            chk("hold_stable", {out_data, out_flags}, {prev_d, prev_f});
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_output: actual %h required none", {out_data, out_flags});
            end else begin
               chk("result", {out_data, out_flags}, q.pop_front());
            end
         end
         stall_prev = out_valid && !out_ready;
         prev_d     = out_data;
         prev_f     = out_flags;
      end
   end

   task automatic send(input logic sg, input logic [7:0] ex, input logic [48:0] mt,
                       input logic [1:0] rm);
      int t;
      in_sign  = sg;
      in_exp   = ex;
      in_mant  = mt;
      in_rmode = rm;
      in_valid = 1'b1;
      @(negedge clk);
      t = 0;
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) chk("accept_timeout", 36'(t), 36'd0);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic sendc(input logic sg, input logic [7:0] ex, input logic [48:0] mt,
                        input logic [1:0] rm, input logic [31:0] d, input logic [3:0] f);
      dir_en  = 1'b1;
      dir_res = {d, f};
      send(sg, ex, mt, rm);
      dir_en  = 1'b0;
   endtask

   task automatic send_rand();
      logic [48:0] mt;
      logic [7:0]  ex;
      mt = 49'({$urandom(), $urandom()});
      mt = mt >> $urandom_range(0, 48);
      if ($urandom_range(0, 15) == 0) mt = '0;
      case ($urandom_range(0, 7))
         0:       ex = 8'hFF;
         1:       ex = 8'($urandom_range(240, 254));
         2:       ex = 8'($urandom_range(0, 30));
         default: ex = 8'($urandom_range(1, 254));
      endcase
      send(1'($urandom_range(0, 1)), ex, mt, 2'($urandom_range(0, 3)));
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (q.size() != 0 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (q.size() != 0) chk("drain_timeout", 36'(q.size()), 36'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;
      logic [48:0] ones;
      ones     = '1;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_sign  = 1'b0;
      in_exp   = '0;
      in_mant  = '0;
      in_rmode = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 36'(out_valid), 36'd0);
      chk("rst_out_data", 36'(out_data), 36'd0);
      chk("rst_out_flags", 36'(out_flags), 36'd0);
      chk("rst_in_ready", 36'(in_ready), 36'd1);
      @(posedge clk);
      #1;

      sendc(1'b0, 8'd127, 49'd1 << 47, 2'd0, 32'h3F800000, 4'b0000);
      lat = 1;
      while (lat < 20) begin
         @(negedge clk);
         if (out_valid) break;
         @(posedge clk);
         lat++;
      end
      chk("latency", 36'(lat), 36'd3);
      @(posedge clk);
      #1;

      sendc(1'b0, 8'd127, 49'd1 << 48, 2'd0, 32'h40000000, 4'b0000);
      sendc(1'b0, 8'd127, 49'd1 << 45, 2'd0, 32'h3E800000, 4'b0000);
      sendc(1'b0, 8'd127, (49'd1 << 47) | (49'd1 << 23), 2'd0, 32'h3F800000, 4'b0010);
      sendc(1'b0, 8'd127, (49'd1 << 47) | (49'd1 << 24) | (49'd1 << 23), 2'd0,
            32'h3F800002, 4'b0010);
      sendc(1'b1, 8'd127, (49'd1 << 47) | (49'd1 << 23), 2'd3, 32'hBF800001, 4'b0010);
      sendc(1'b0, 8'd127, ones, 2'd0, 32'h40800000, 4'b0010);
      sendc(1'b0, 8'd254, ones, 2'd0, 32'h7F800000, 4'b1010);
      sendc(1'b0, 8'd254, ones, 2'd1, 32'h7F7FFFFF, 4'b1010);
      sendc(1'b1, 8'd254, ones, 2'd2, 32'hFF7FFFFF, 4'b1010);
      sendc(1'b1, 8'd254, ones, 2'd3, 32'hFF800000, 4'b1010);
      sendc(1'b1, 8'd100, 49'd0, 2'd0, 32'h80000000, 4'b0001);
      sendc(1'b0, 8'd1, 49'd1 << 44, 2'd0, 32'h00000000, 4'b0111);
      sendc(1'b0, 8'd255, 49'd5, 2'd0, 32'h7FC00000, 4'b0000);
      sendc(1'b1, 8'd255, 49'd0, 2'd1, 32'hFF800000, 4'b0000);
      drain();

      fork
         begin
            for (int k = 0; k < 6; k++) send_rand();
         end
         begin
            int t;
            t = 0;
            @(negedge clk);
            while (!out_valid && t < 50) begin
               @(negedge clk);
               t++;
            end
            chk("bp_first_valid", 36'(out_valid), 36'd1);
            rdy_mode = 1;
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               chk("bp_in_ready_low", 36'(in_ready), 36'd0);
            end
            rdy_mode = 0;
         end
      join
      drain();

      rdy_mode = 2;
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         send_rand();
      end
      @(negedge clk);
      rdy_mode = 0;
      drain();

      send_rand();
      send_rand();
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_flush_valid", 36'(out_valid), 36'd0);
      repeat (10) @(negedge clk);
      chk("rst_flush_queue", 36'(q.size()), 36'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
